// File: rtl/acc_cla_pkg.sv
// acc_cla_pkg: shared definitions for the streaming frame accumulator.
//   S_ACC / S_OUT : FSM state encodings (1 bit).
//   BW_DATA_DEF   : default operand/sum width.
//   FRAME_LEN_DEF : default number of operands per frame.
package acc_cla_pkg;

    localparam int unsigned BW_DATA_DEF   = 32;
    localparam int unsigned FRAME_LEN_DEF = 4;

    localparam logic [0:0] S_ACC = 1'b0;
    localparam logic [0:0] S_OUT = 1'b1;

endpackage

// File: rtl/acc_cla_if.sv
// acc_cla_if: operand stream in, frame result out.
//   i_data/i_valid/o_ready : upstream operand handshake.
//   o_sum/o_ovf/o_valid/i_ready : downstream result handshake.
//   master : the side that produces operands and consumes results.
//   slave  : the accumulator.
interface acc_cla_if
    import acc_cla_pkg::*;
#(
    parameter int unsigned BW_DATA = BW_DATA_DEF
);
    logic [BW_DATA-1:0] i_data;
    logic               i_valid;
    logic               o_ready;
    logic [BW_DATA-1:0] o_sum;
    logic               o_ovf;
    logic               o_valid;
    logic               i_ready;

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_sum, o_ovf, o_valid
    );

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_sum, o_ovf, o_valid
    );
endinterface

// File: rtl/adder_cla.sv
// adder_cla: carry-lookahead adder built from 4-bit lookahead groups, with
// group generate/propagate feeding a group-level carry lookahead.
//   i_a, i_b : operands (BW bits, BW a multiple of 4)
//   i_c      : carry-in
//   o_s      : sum modulo 2^BW
//   o_c      : carry-out
module adder_cla #(
    parameter int unsigned BW = 32
) (
    input  logic [BW-1:0] i_a,
    input  logic [BW-1:0] i_b,
    input  logic          i_c,
    output logic [BW-1:0] o_s,
    output logic          o_c
);
    localparam int unsigned NG = BW / 4;

    logic [BW-1:0] g;
    logic [BW-1:0] p;
    logic [BW:0]   c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;

    always_comb begin
        g  = i_a & i_b;
        p  = i_a ^ i_b;
        gg = '0;
        gp = '1;
        c  = '0;
        gc = '0;
        // group generate/propagate
        for (int unsigned k = 0; k < NG; k++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
                gp[k] = gp[k] & p[4*k+j];
            end
        end
        // carry into each group
        gc[0] = i_c;
        for (int unsigned k = 0; k < NG; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        // carries inside each group, seeded from the group carry
        for (int unsigned k = 0; k < NG; k++) begin
            c[4*k] = gc[k];
            for (int unsigned j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[BW] = gc[NG];
        o_s   = p ^ c[BW-1:0];
        o_c   = c[BW];
    end
endmodule

// File: rtl/acc_cla.sv
// acc_cla: streaming frame accumulator. Sums FRAME_LEN accepted operands per
// frame through adder_cla and presents the sum plus a sticky carry-out flag.
//   i_clk  : clock, rising edge
//   i_rstn : asynchronous active-low reset
//   bus    : acc_cla_if.slave (operand in, result out)
// Optional build macro ACC_CLA_SATURATE_EN: after the first carry-out of a
// frame the running sum is clamped to all-ones for the rest of the frame.
module acc_cla
    import acc_cla_pkg::*;
#(
    parameter int unsigned BW_DATA   = BW_DATA_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned BW_CNT    = $clog2(FRAME_LEN) + 1
) (
    input  logic     i_clk,
    input  logic     i_rstn,
    acc_cla_if.slave bus
);
    logic [0:0]         state;
    logic [BW_DATA-1:0] acc;
    logic [BW_CNT-1:0]  cnt;
    logic               ovf;
    logic [BW_DATA-1:0] sum_q;
    logic               ovf_q;
    logic               valid_q;

    logic [BW_DATA-1:0] add_s;
    logic               add_c;
    logic [BW_DATA-1:0] acc_nxt;
    logic               ovf_nxt;
    logic               last;

    adder_cla #(.BW(BW_DATA)) u_adder (
        .i_a (acc),
        .i_b (bus.i_data),
        .i_c (1'b0),
        .o_s (add_s),
        .o_c (add_c)
    );

    assign ovf_nxt = ovf | add_c;
`ifdef ACC_CLA_SATURATE_EN
    assign acc_nxt = ovf_nxt ? '1 : add_s;
`else
    assign acc_nxt = add_s;
`endif
    assign last = (cnt == BW_CNT'(FRAME_LEN - 1));

    assign bus.o_ready = (state == S_ACC);
    assign bus.o_sum   = sum_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_valid = valid_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= S_ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (state == S_ACC) begin
            if (bus.i_valid) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    sum_q   <= acc_nxt;
                    ovf_q   <= ovf_nxt;
                    valid_q <= 1'b1;
                    state   <= S_OUT;
                end
            end
        end else begin
            if (bus.i_ready) begin
                valid_q <= 1'b0;
                acc     <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
                state   <= S_ACC;
            end
        end
    end
endmodule

// File: doc/acc_cla.md
Name: acc_cla

Overview:
- Streaming frame accumulator built on the team's 32-bit carry-lookahead adder.
- Consumes a stream of operands over a valid/ready handshake and sums FRAME_LEN operands per frame.
- Presents the frame sum plus an overflow flag on a downstream valid/ready port.
- Sits directly around the CLA adder: registers its inputs and consumes its o_s/o_c every accepted beat.

Parameters:
- BW_DATA, 32, operand and sum width in bits.
- FRAME_LEN, 4, operands per frame; legal range 1..2^BW_CNT.
- BW_CNT, $clog2(FRAME_LEN)+1, width of the beat counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_data  in  BW_DATA  operand.
- i_valid  in  1  operand valid.
- o_ready  out  1  block can accept an operand this cycle.
- o_sum  out  BW_DATA  frame sum; stable while o_valid=1.
- o_ovf  out  1  at least one carry-out occurred within the frame.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (i_rstn=0, asynchronous), all cleared immediately:
  - state=S_ACC, acc=0, cnt=0, ovf=0.
  - o_sum=0, o_ovf=0, o_valid=0.
  - o_ready=1 once reset is released.
  - A reset mid-frame discards the partial sum; no result is emitted.
- Adder use:
  - Single adder_cla instance with i_a=acc, i_b=i_data, i_c=0.
  - Sum is modulo 2^BW_DATA; the carry-out is ORed into ovf.
- FSM, 2 states; o_ready = (state==S_ACC), purely combinational from state.
- S_ACC, on accept (i_valid & o_ready):
  - acc<=o_s, ovf<=ovf|o_c, cnt<=cnt+1.
  - If cnt==FRAME_LEN-1 at accept: o_sum<=o_s, o_ovf<=ovf|o_c, o_valid<=1, go S_OUT.
  - Without i_valid: hold all state.
- S_OUT:
  - o_valid=1; o_sum and o_ovf held.
  - i_valid is ignored and no data is consumed.
  - On i_ready: o_valid<=0, acc<=0, cnt<=0, ovf<=0, go S_ACC.
- Latency:
  - o_valid rises one cycle after the last operand is accepted.
  - Minimum frame period is FRAME_LEN+1 cycles (one bubble per frame).
- FRAME_LEN=1: every accepted operand produces a result equal to the operand, o_ovf=0.
- i_ready high while in S_ACC has no effect.
- i_valid dropping mid-frame stalls the frame with no loss of data.
- Counter never exceeds FRAME_LEN-1 in S_ACC.

Optional Feature:
- Macro ACC_CLA_SATURATE_EN.
- Defined:
  - Once a carry-out occurs, acc is clamped to all-ones ({BW_DATA{1'b1}}) and stays all-ones for the rest of the frame.
  - o_sum shows the saturated value; o_ovf still reports the event.
- Undefined: wrap-around sum as described above.
- Port list is identical in both builds.

Decomposition:
- Shared package/header holds:
  - State encoding localparams S_ACC=1'b0, S_OUT=1'b1.
  - Defaults BW_DATA and FRAME_LEN.
- Sub-module: adder_cla (existing 32-bit CLA) as the only child.
- FSM, counter and registers are inline.

Test Plan:
- Reset, then 4 beats 1,2,3,4 with i_ready=1 -> o_valid one cycle after the 4th accept; o_sum=10, o_ovf=0; o_ready=0 for exactly 1 cycle.
- Beats 0xFFFFFFFF,2,0,0 -> o_sum=0x00000001, o_ovf=1. With ACC_CLA_SATURATE_EN: o_sum=0xFFFFFFFF, o_ovf=1.
- i_valid gapped (beats on cycles 0,3,4,9) with values 5,5,5,5 -> o_sum=20, single result, no lost beat.
- i_ready held 0 for 6 cycles after o_valid -> o_valid, o_sum and o_ovf stable; o_ready=0; i_valid beats not accepted. Then i_ready=1 -> next frame starts from acc=0.
- Assert i_rstn=0 asynchronously after 2 beats (7,8), then 4 beats of 1 -> o_valid stays 0 during reset; result o_sum=4.
- FRAME_LEN=1 build: beats 9,0xA -> two results, 9 then 0xA, each o_ovf=0.
